// File: rtl/zmod_rx_checker.sv
// zmod_rx_checker: per-lane bit-slip aligner plus sync/counting-data checker.
// Optional macro ZMOD_RX_CHECKER_BITERR_EN builds the errored-bit counter.
// Ports: clk, rst_n, din[31:0] (lane3 sync, lanes2..0 data), din_valid, clr_counts;
//        dout[23:0], dout_valid, shift[2:0], locked, frame_err,
//        err_count, word_count, bit_err_count (32-bit, saturating).
module zmod_rx_checker #(
  parameter int unsigned LOCK_COUNT = 8,
  parameter int unsigned LOSS_COUNT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] din,
  input  logic        din_valid,
  input  logic        clr_counts,
  output logic [23:0] dout,
  output logic        dout_valid,
  output logic [2:0]  shift,
  output logic        locked,
  output logic        frame_err,
  output logic [31:0] err_count,
  output logic [31:0] word_count,
  output logic [31:0] bit_err_count
);

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam logic [7:0]  LOCK_N = 8'(LOCK_COUNT);
  localparam logic [7:0]  LOSS_N = 8'(LOSS_COUNT);
  localparam logic [31:0] SAT    = 32'hFFFF_FFFF;

  logic [1:0]  state;
  logic [31:0] cur;
  logic [31:0] prev;
  logic        fill;
  logic [7:0]  sync_al;
  logic [23:0] last_data;
  logic [23:0] expected;
  logic [7:0]  good_cnt;
  logic [7:0]  miss_cnt;
  logic        sync_hot;
  logic [2:0]  sync_idx;
  logic [31:0] aligned;
  logic        sync_ok;
  logic        word_ok;
  logic        chk_lock;
  logic        bad_lock;

  function automatic logic [7:0] align8(
    input logic [7:0] p,
    input logic [7:0] c,
    input logic [2:0] s
  );
    logic [15:0] w;
    w = {p, c} >> s;
    return w[7:0];
  endfunction

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v
  );
    return (v == SAT) ? v : v + 32'd1;
  endfunction

  // The low s bits of the previous byte complete the current one.
  for (genvar g = 0; g < 4; g++) begin : g_lane
    assign aligned[8*g +: 8] =
      align8(prev[8*g +: 8], cur[8*g +: 8], shift);
  end

  always_comb begin
    sync_hot = 1'b1;
    sync_idx = 3'd0;
    case (din[31:24])
      8'h01:   sync_idx = 3'd0;
      8'h02:   sync_idx = 3'd1;
      8'h04:   sync_idx = 3'd2;
      8'h08:   sync_idx = 3'd3;
      8'h10:   sync_idx = 3'd4;
      8'h20:   sync_idx = 3'd5;
      8'h40:   sync_idx = 3'd6;
      8'h80:   sync_idx = 3'd7;
      default: sync_hot = 1'b0;
    endcase
  end

  assign expected = last_data + 24'd1;
  assign sync_ok  = (sync_al == 8'h01);
  assign word_ok  = sync_ok && (dout == expected);
  assign chk_lock = dout_valid && (state == ST_LOCKED);
  assign bad_lock = chk_lock && !word_ok;
  assign locked   = (state == ST_LOCKED);

  // fill suppresses dout_valid for the word built from reset contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur        <= '0;
      prev       <= '0;
      fill       <= 1'b0;
      dout       <= '0;
      sync_al    <= '0;
      dout_valid <= 1'b0;
      shift      <= '0;
    end else if (din_valid) begin
      cur        <= din;
      prev       <= cur;
      fill       <= 1'b1;
      dout       <= aligned[23:0];
      sync_al    <= aligned[31:24];
      dout_valid <= fill;
      if (state == ST_HUNT && sync_hot) begin
        shift <= sync_idx;
      end
    end else begin
      dout_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_HUNT;
      good_cnt  <= '0;
      miss_cnt  <= '0;
      last_data <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= bad_lock;
      if (dout_valid) begin
        unique case (state)
          ST_HUNT: begin
            if (sync_ok) begin
              state     <= ST_VERIFY;
              good_cnt  <= 8'd1;
              last_data <= dout;
            end
          end
          ST_VERIFY: begin
            if (word_ok) begin
              last_data <= dout;
              good_cnt  <= good_cnt + 8'd1;
              if (good_cnt + 8'd1 == LOCK_N) begin
                state    <= ST_LOCKED;
                miss_cnt <= '0;
              end
            end else begin
              state <= ST_HUNT;
            end
          end
          ST_LOCKED: begin
            if (word_ok) begin
              miss_cnt  <= '0;
              last_data <= dout;
            end else begin
              // Re-sync to the predicted value so one bad word costs one error.
              last_data <= expected;
              miss_cnt  <= miss_cnt + 8'd1;
              if (miss_cnt + 8'd1 == LOSS_N) begin
                state <= ST_HUNT;
              end
            end
          end
          default: state <= ST_HUNT;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count  <= '0;
      word_count <= '0;
    end else if (clr_counts) begin
      err_count  <= '0;
      word_count <= '0;
    end else begin
      if (chk_lock) begin
        word_count <= sat_inc(word_count);
      end
      if (bad_lock) begin
        err_count <= sat_inc(err_count);
      end
    end
  end

`ifdef ZMOD_RX_CHECKER_BITERR_EN
  logic [4:0]  bit_diff;
  logic [32:0] bit_sum;

  assign bit_diff = 5'($countones(dout ^ expected));
  assign bit_sum  = {1'b0, bit_err_count} + {28'd0, bit_diff};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_err_count <= '0;
    end else if (clr_counts) begin
      bit_err_count <= '0;
    end else if (bad_lock) begin
      bit_err_count <= bit_sum[32] ? SAT : bit_sum[31:0];
    end
  end
`else
  assign bit_err_count = '0;
`endif

endmodule

// File: tb/tb_zmod_rx_checker.sv
// tb_zmod_rx_checker: scenario table plus a word-level reference model
// checked against zmod_rx_checker every cycle.
module tb_zmod_rx_checker;

  localparam int LOCK_N = 8;
  localparam int LOSS_N = 4;
`ifdef ZMOD_RX_CHECKER_BITERR_EN
  localparam int BE = 1;
`else
  localparam int BE = 0;
`endif
  localparam longint CAP = 64'h0000_0000_FFFF_FFFF;

  logic        clk;
  logic        rst_n;
  logic [31:0] din;
  logic        din_valid;
  logic        clr_counts;
  logic [23:0] dout;
  logic        dout_valid;
  logic [2:0]  shift;
  logic        locked;
  logic        frame_err;
  logic [31:0] err_count;
  logic [31:0] word_count;
  logic [31:0] bit_err_count;

  zmod_rx_checker #(
    .LOCK_COUNT(LOCK_N),
    .LOSS_COUNT(LOSS_N)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .din(din),
    .din_valid(din_valid),
    .clr_counts(clr_counts),
    .dout(dout),
    .dout_valid(dout_valid),
    .shift(shift),
    .locked(locked),
    .frame_err(frame_err),
    .err_count(err_count),
    .word_count(word_count),
    .bit_err_count(bit_err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int slip;
    int start;
    int nwords;
    int bad_at;
    int xmask;
    int zero_at;
    int clr_win;
    int gaps;
    int rnd;
    int check_final;
    int exp_locked;
    int exp_err;
    int exp_bits;
    int exp_shift;
  } vec_t;

  vec_t tbl [9];
  int checks;
  int errors;

  // Reference model: mode 0 searching, 1 confirming, 2 locked.
  logic [31:0] m_cur;
  logic [31:0] m_prev;
  bit          m_fill;
  bit          m_dv;
  bit          m_fe;
  logic [23:0] m_dout;
  logic [23:0] m_last;
  logic [7:0]  m_sync;
  logic [2:0]  m_shift;
  int          m_mode;
  int          m_good;
  int          m_miss;
  longint      m_err;
  longint      m_words;
  longint      m_bits;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, want, $time);
    end
  endtask

  task automatic model_reset();
    m_cur = '0; m_prev = '0; m_fill = 0; m_dv = 0; m_fe = 0;
    m_dout = '0; m_last = '0; m_sync = '0; m_shift = '0;
    m_mode = 0; m_good = 0; m_miss = 0;
    m_err = 0; m_words = 0; m_bits = 0;
  endtask

  task automatic model_edge();
    logic [23:0] e;
    logic [23:0] diff;
    logic [31:0] al;
    logic [15:0] w16;
    bit          ok;
    int          pc;
    int          n_mode, n_good, n_miss;
    logic [23:0] n_last;
    bit          n_fe;
    longint      n_err, n_words, n_bits;
    if (!rst_n) begin
      model_reset();
      return;
    end
    e = m_last + 24'd1;
    ok = (m_sync == 8'h01) && (m_dout == e);
    n_mode = m_mode; n_good = m_good; n_miss = m_miss;
    n_last = m_last; n_fe = 0;
    n_err = m_err; n_words = m_words; n_bits = m_bits;
    if (m_dv) begin
      if (m_mode == 0) begin
        if (m_sync == 8'h01) begin
          n_mode = 1; n_good = 1; n_last = m_dout;
        end
      end else if (m_mode == 1) begin
        if (ok) begin
          n_good = m_good + 1;
          n_last = m_dout;
          if (n_good >= LOCK_N) begin
            n_mode = 2; n_miss = 0;
          end
        end else begin
          n_mode = 0;
        end
      end else begin
        n_words = (m_words + 1 > CAP) ? CAP : m_words + 1;
        if (ok) begin
          n_miss = 0; n_last = m_dout;
        end else begin
          n_fe = 1;
          n_err = (m_err + 1 > CAP) ? CAP : m_err + 1;
          n_miss = m_miss + 1;
          n_last = e;
          diff = m_dout ^ e;
          pc = 0;
          for (int i = 0; i < 24; i++) pc += int'(diff[i]);
          if (BE != 0) n_bits = (m_bits + pc > CAP) ? CAP : m_bits + pc;
          if (n_miss >= LOSS_N) n_mode = 0;
        end
      end
    end
    if (clr_counts) begin
      n_err = 0; n_words = 0; n_bits = 0;
    end
    if (din_valid) begin
      for (int L = 0; L < 4; L++) begin
        w16 = {m_prev[8*L +: 8], m_cur[8*L +: 8]} >> m_shift;
        al[8*L +: 8] = w16[7:0];
      end
      m_dout = al[23:0];
      m_sync = al[31:24];
      m_dv = m_fill;
      m_prev = m_cur;
      m_cur = din;
      m_fill = 1;
      if (m_mode == 0 && $onehot(din[31:24])) begin
        for (int i = 0; i < 8; i++) if (din[24+i]) m_shift = 3'(i);
      end
    end else begin
      m_dv = 0;
    end
    m_mode = n_mode; m_good = n_good; m_miss = n_miss;
    m_last = n_last; m_fe = n_fe;
    m_err = n_err; m_words = n_words; m_bits = n_bits;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("dout", 32'(dout), 32'(m_dout));
    chk("dout_valid", 32'(dout_valid), 32'(m_dv));
    chk("shift", 32'(shift), 32'(m_shift));
    chk("locked", 32'(locked), 32'(m_mode == 2));
    chk("frame_err", 32'(frame_err), 32'(m_fe));
    chk("err_count", err_count, m_err[31:0]);
    chk("word_count", word_count, m_words[31:0]);
    chk("bit_err_count", bit_err_count, m_bits[31:0]);
  endtask

  // Lane byte as seen on the wire when the stream is slipped by s bits.
  function automatic logic [31:0] make_din(input logic [31:0] x,
                                           input logic [31:0] y,
                                           input int s);
    logic [15:0] w;
    logic [31:0] r;
    r = '0;
    for (int L = 0; L < 4; L++) begin
      w = {x[8*L +: 8], y[8*L +: 8]} >> (8 - s);
      r[8*L +: 8] = w[7:0];
    end
    return r;
  endfunction

  task automatic do_reset();
    din = '0; din_valid = 0; clr_counts = 0;
    rst_n = 0;
    #1;
    chk("rst_dout", 32'(dout), 0);
    chk("rst_dout_valid", 32'(dout_valid), 0);
    chk("rst_shift", 32'(shift), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_frame_err", 32'(frame_err), 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_word_count", word_count, 0);
    chk("rst_bit_err_count", bit_err_count, 0);
    model_reset();
    tick();
    tick();
    #2 rst_n = 1;
  endtask

  task automatic run_stream(input vec_t v);
    logic [31:0] a[$];
    logic [31:0] w;
    do_reset();
    a.delete();
    for (int k = 0; k <= v.nwords; k++) begin
      w = {8'h01, 24'(v.start + k)};
      if (k == v.bad_at) w[23:0] = w[23:0] ^ 24'(v.xmask);
      if (v.zero_at >= 0 && k >= v.zero_at && k < v.zero_at + 4)
        w[31:24] = 8'h00;
      if (v.rnd != 0 && $urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 1)
          w[23:0] = w[23:0] ^ 24'($urandom_range(1, 32'h00FF_FFFF));
        else
          w[31:24] = 8'($urandom);
      end
      a.push_back(w);
    end
    for (int k = 0; k < v.nwords; k++) begin
      if (v.gaps != 0) begin
        repeat ($urandom_range(0, 2)) begin
          din = $urandom; din_valid = 0; clr_counts = 0;
          tick();
        end
      end
      din = make_din(a[k], a[k+1], v.slip);
      din_valid = 1;
      clr_counts = (v.clr_win != 0 && k >= v.bad_at + 1 && k <= v.bad_at + 3);
      tick();
    end
    din_valid = 0;
    clr_counts = 0;
    repeat (4) tick();
  endtask

  initial begin
    logic [31:0] ra[$];
    checks = 0; errors = 0;
    rst_n = 0; din = '0; din_valid = 0; clr_counts = 0;
    //         slip start      n   bad xmsk    zero clr gap rnd fin lk err bits     sh
    tbl[0] = '{0, 'h000100, 30, -1, 0,      -1,  0,  0,  0,  1,  1, 0, 0,       0};
    tbl[1] = '{5, 'h000100, 30, -1, 0,      -1,  0,  0,  0,  1,  1, 0, 0,       5};
    tbl[2] = '{0, 'h000100, 30, 20, 'h3,    -1,  0,  0,  0,  1,  1, 1, 2 * BE,  0};
    tbl[3] = '{3, 'h000100, 45, -1, 0,      20,  0,  0,  0,  1,  1, 4, 0,       3};
    tbl[4] = '{2, 'hFFFFF0, 30, -1, 0,      -1,  0,  0,  0,  1,  1, 0, 0,       2};
    tbl[5] = '{0, 'h000200, 35, 25, 'h400,  -1,  1,  0,  0,  1,  1, 0, 0,       0};
    tbl[6] = '{6, 'h000300, 40, -1, 0,      -1,  0,  1,  0,  1,  1, 0, 0,       6};
    tbl[7] = '{4, 'h001000, 80, -1, 0,      -1,  0,  0,  1,  0,  0, 0, 0,       0};
    tbl[8] = '{7, 'h002000, 80, -1, 0,      -1,  0,  1,  1,  0,  0, 0, 0,       0};

    for (int i = 0; i < 9; i++) begin
      run_stream(tbl[i]);
      if (tbl[i].check_final != 0) begin
        chk($sformatf("v%0d_locked", i), 32'(locked), tbl[i].exp_locked);
        chk($sformatf("v%0d_err", i), err_count, tbl[i].exp_err);
        chk($sformatf("v%0d_bits", i), bit_err_count, tbl[i].exp_bits);
        chk($sformatf("v%0d_shift", i), 32'(shift), tbl[i].exp_shift);
      end
    end

    // Reset while locked on a slipped stream, then relock on an aligned one.
    run_stream(tbl[1]);
    chk("pre_rst_locked", 32'(locked), 1);
    do_reset();
    for (int k = 0; k <= 14; k++) ra.push_back({8'h01, 24'(32'h700 + k)});
    for (int k = 0; k < 14; k++) begin
      din = make_din(ra[k], ra[k+1], 0);
      din_valid = 1;
      tick();
      chk("relock_edge", 32'(locked), 32'(k + 1 >= LOCK_N + 2));
    end
    din_valid = 0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/zmod_rx_checker.md
ZMOD_RX_CHECKER -- requirements
Module: zmod_rx_checker

Interface
REQ-001 LOCK_COUNT, 8, consecutive good aligned words in VERIFY needed to enter LOCKED (range 2-255).
REQ-002 LOSS_COUNT, 4, consecutive bad words in LOCKED that force return to HUNT (range 1-255).
REQ-003 clk  in  1  rx divided clock; every register is clocked on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 din  in  32  deserialized lane bytes: lane i is bits [8i+7:8i]; lane 3 is sync, lanes 2..0 are data.
REQ-006 din_valid  in  1  din qualifier; when low, the block holds all state and performs no checks.
REQ-007 clr_counts  in  1  synchronous clear of err_count, word_count and bit_err_count.
REQ-008 dout  out  24  aligned data word {lane2,lane1,lane0}.
REQ-009 dout_valid  out  1  dout qualifier.
REQ-010 shift  out  3  current bit-slip value.
REQ-011 locked  out  1  high while the FSM is in LOCKED.
REQ-012 frame_err  out  1  one-cycle pulse for each bad word checked in LOCKED.
REQ-013 err_count  out  32  saturating count of bad words in LOCKED.
REQ-014 word_count  out  32  saturating count of words checked in LOCKED.
REQ-015 bit_err_count  out  32  saturating count of errored data bits (see Configuration).

Function
REQ-016 Stage 1, on a valid cycle: cur <= din and prev <= cur; in HUNT, shift <= index of the single set bit of din[31:24] when that byte is one-hot, otherwise shift is unchanged.
REQ-017 shift is frozen in VERIFY and LOCKED.
REQ-018 Stage 2: each lane's aligned byte = bits [7:0] of ({prev_lane, cur_lane} >> shift); dout and dout_valid are registered 2 valid cycles after din is sampled.
REQ-019 A word is good iff the aligned sync byte == 8'h01 and dout == (expected) mod 2^24, where expected = last_data + 1.
REQ-020 HUNT: an aligned sync byte equal to 8'h01 -> VERIFY, with good_cnt = 1 and last_data = dout; no data compare is made on that word.
REQ-021 VERIFY: a good word increments good_cnt and sets last_data = dout; when good_cnt reaches LOCK_COUNT -> LOCKED with miss_cnt = 0; a bad word -> HUNT.
REQ-022 LOCKED: a good word clears miss_cnt; a bad word pulses frame_err, increments err_count and miss_cnt, and sets last_data = expected, so a single corrupted word costs exactly one error.
REQ-023 LOCKED: when miss_cnt reaches LOSS_COUNT -> HUNT and locked deasserts.
REQ-024 frame_err, FSM transitions and counter updates take effect 1 cycle after the checked dout_valid cycle.
REQ-025 Counters saturate at 32'hFFFF_FFFF and do not wrap; expected wraps from 24'hFFFFFF to 24'h000000 without error.
REQ-026 When clr_counts coincides with an increment, the clear wins; clr_counts does not affect FSM state.

Reset
REQ-027 While rst_n is low: FSM = HUNT, shift = 0, cur/prev/dout/last_data = 0, dout_valid = 0, locked = 0, frame_err = 0, and all counters = 0.
REQ-028 Reset asserted mid-operation returns the FSM to HUNT immediately (asynchronously); operation resumes on the first valid cycle after rst_n deasserts.

Configuration
REQ-029 Macro ZMOD_RX_CHECKER_BITERR_EN.
REQ-030 Defined: for each bad word in LOCKED, bit_err_count += popcount(dout XOR expected), saturating.
REQ-031 Undefined: bit_err_count is tied to 0 and no popcount logic is built; all other behaviour is identical.

Verification
REQ-032 Aligned stream (sync 8'h01, data counting up from 0x000100) -> locked asserts on the 8th good word after HUNT exit; err_count = 0.
REQ-033 Stream slipped by 5 bits on all lanes -> shift = 5, dout sequence increments by 1, locked = 1.
REQ-034 When locked, corrupt one word's data with 0x000003 -> exactly one frame_err pulse; err_count = 1; bit_err_count = 2 (macro defined); FSM stays LOCKED.
REQ-035 When locked, 4 consecutive words with sync = 8'h00 -> locked drops 1 cycle after the 4th word; FSM relocks afterwards.
REQ-036 Data passes 24'hFFFFFE -> 24'hFFFFFF -> 24'h000000 -> no error; pulsing clr_counts together with an error -> err_count = 0.
REQ-037 rst_n pulsed low while locked -> all outputs are 0 immediately; relock occurs after LOCK_COUNT + 2 valid cycles.
